// File: rtl/sm83_pkg.sv
// Shared constants and types for the sm83 interrupt path: source indices,
// register addresses and the core-facing irq vector type.
package sm83_pkg;

  localparam int NUM_IRQS = 8;
  localparam int NUM_SRC  = 5;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] ADR_IF = 16'hFF0F;
  localparam logic [15:0] ADR_IE = 16'hFFFF;

  typedef logic [NUM_IRQS-1:0] irq_t;

endpackage

// File: rtl/sm83_irq_edge.sv
// Level-to-pulse rising-edge detector. The history register tracks the input
// on every clock, including under reset, so a level held through reset never
// looks like an edge afterwards.
module sm83_irq_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_lvl,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_lvl;

  always_ff @(posedge clk) begin
    r_lvl <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_lvl & {W{~reset}};

endmodule

// File: rtl/sm83_irq_ctl.sv
// IF/IE interrupt controller feeding the sm83 core: latches peripheral request
// edges into IF, masks with IE, clears on acknowledge, and exposes both on a bus.
module sm83_irq_ctl
  import sm83_pkg::*;
#(
  parameter int          NUM_IRQS = sm83_pkg::NUM_IRQS,
  parameter int          NUM_SRC  = sm83_pkg::NUM_SRC,
  parameter logic [15:0] ADR_IF   = sm83_pkg::ADR_IF,
  parameter logic [15:0] ADR_IE   = sm83_pkg::ADR_IE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         adr,
  input  logic [7:0]          din,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [7:0]          dout,
  output logic                dout_valid,
  input  logic [NUM_SRC-1:0]  req,
  output logic [NUM_IRQS-1:0] irq,
  input  logic [NUM_IRQS-1:0] iack,
  output logic                irq_any
);

  logic [NUM_SRC-1:0] r_if;
  logic [7:0]         r_ie;
  logic [7:0]         r_dout;
  logic               r_dout_valid;

  logic [NUM_SRC-1:0] w_rise;
  logic               w_hit_if;
  logic               w_hit_ie;
  logic               w_wr_if;
  logic               w_wr_ie;
  logic               w_unused_iack;

  sm83_irq_edge #(.W(NUM_SRC)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_lvl  (req),
    .o_rise (w_rise)
  );

  assign w_hit_if = (adr == ADR_IF);
  assign w_hit_ie = (adr == ADR_IE);
  assign w_wr_if  = wr_en & w_hit_if;
  assign w_wr_ie  = wr_en & w_hit_ie;

  // Acks for unimplemented sources have nothing to clear.
  assign w_unused_iack = &{1'b0, iack[NUM_IRQS-1:NUM_SRC]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if         <= '0;
      r_ie         <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      // A fresh edge outranks both ack and bus write so it is never lost.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_rise[i])
          r_if[i] <= 1'b1;
        else if (iack[i])
          r_if[i] <= 1'b0;
        else if (w_wr_if)
          r_if[i] <= din[i];
      end
      if (w_wr_ie)
        r_ie <= din;
      r_dout_valid <= rd_en & (w_hit_if | w_hit_ie);
      if (rd_en && w_hit_if)
        r_dout <= {{(8-NUM_SRC){1'b1}}, r_if};
      else if (rd_en && w_hit_ie)
        r_dout <= r_ie;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQS; gi++) begin : g_irq
      if (gi < NUM_SRC) begin : g_src
        assign irq[gi] = r_if[gi] & r_ie[gi];
      end else begin : g_none
        assign irq[gi] = 1'b0;
      end
    end
  endgenerate

  assign irq_any    = |irq;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a per-source behavioural model of IF/IE.
module tb_sm83_irq_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic        wr_en, rd_en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [4:0]  req;
  logic [7:0]  irq;
  logic [7:0]  iack;
  logic        irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending flag per source, enable byte, bus read state.
  bit       m_pend [5];
  bit [7:0] m_en;
  bit [4:0] m_last_req;
  bit [7:0] m_rdata;
  bit       m_rvalid;
  bit       m_ok = 0;

  always #5 clk = ~clk;

  sm83_irq_ctl dut (
    .clk        (clk),
    .reset      (reset),
    .adr        (adr),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .req        (req),
    .irq        (irq),
    .iack       (iack),
    .irq_any    (irq_any)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] model_irq();
    bit [7:0] v = 8'h00;
    for (int i = 0; i < 5; i++)
      if (m_pend[i] && m_en[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit [7:0] model_if_byte();
    bit [7:0] v = 8'hE0;
    for (int i = 0; i < 5; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step();
    bit [7:0] old_if = model_if_byte();
    bit [7:0] old_en = m_en;
    if (reset) begin
      for (int i = 0; i < 5; i++) m_pend[i] = 0;
      m_en = 0; m_rdata = 0; m_rvalid = 0; m_last_req = req;
      m_ok = 1;
      return;
    end
    m_rvalid = 0;
    if (rd_en && adr == 16'hFF0F) begin m_rdata = old_if; m_rvalid = 1; end
    if (rd_en && adr == 16'hFFFF) begin m_rdata = old_en; m_rvalid = 1; end
    for (int i = 0; i < 5; i++) begin
      if (req[i] && !m_last_req[i])        m_pend[i] = 1;
      else if (iack[i])                     m_pend[i] = 0;
      else if (wr_en && adr == 16'hFF0F)    m_pend[i] = din[i];
    end
    if (wr_en && adr == 16'hFFFF) m_en = din;
    m_last_req = req;
  endtask

  // Apply one cycle of inputs at negedge, step the model at posedge, compare at next negedge.
  task automatic cyc(input bit rst, input logic [15:0] a, input logic [7:0] d,
                     input bit w, input bit r, input logic [4:0] rq, input logic [7:0] ak);
    reset = rst; adr = a; din = d; wr_en = w; rd_en = r; req = rq; iack = ak;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_ok) begin
      check("irq", {8'h00, irq}, {8'h00, model_irq()});
      check("irq_any", {15'h0, irq_any}, {15'h0, |model_irq()});
      check("dout_valid", {15'h0, dout_valid}, {15'h0, m_rvalid});
      check("dout", {8'h00, dout}, {8'h00, m_rdata});
    end
  endtask

  task automatic idle(input logic [4:0] rq);
    cyc(0, 16'h0000, 8'h00, 0, 0, rq, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a, input logic [4:0] rq);
    cyc(0, a, 8'h00, 0, 1, rq, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [4:0] rq);
    cyc(0, a, d, 1, 0, rq, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    // Reset with VBlank held high: no edge may appear afterwards.
    cyc(1, 16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00);
    cyc(1, 16'h0000, 8'h00, 0, 0, 5'b00001, 8'h00);
    check("rst_dout_valid", {15'h0, dout_valid}, 16'h0);
    check("rst_dout", {8'h0, dout}, 16'h0);
    for (int k = 0; k < 4; k++) idle(5'b00001);
    check("rst_irq", {8'h0, irq}, 16'h0);
    rd(16'hFF0F, 5'b00001);
    check("rst_if_read", {8'h0, dout}, 16'h00E0);

    // Timer edge, then ack.
    wr(16'hFFFF, 8'h05, 5'b00001);
    idle(5'b00101);
    check("timer_irq", {8'h0, irq}, 16'h0004);
    check("timer_any", {15'h0, irq_any}, 16'h1);
    cyc(0, 16'h0000, 8'h00, 0, 0, 5'b00101, 8'h04);
    check("timer_ack_irq", {8'h0, irq}, 16'h0);
    rd(16'hFF0F, 5'b00101);
    check("timer_ack_if", {8'h0, dout}, 16'h00E0);

    // Two simultaneous edges, then ack of one racing a new edge.
    wr(16'hFFFF, 8'h1F, 5'b00000);
    idle(5'b01001);
    check("dual_irq", {8'h0, irq}, 16'h0009);
    cyc(0, 16'h0000, 8'h00, 0, 0, 5'b01011, 8'h01);
    check("ack_edge_irq", {8'h0, irq}, 16'h000A);
    rd(16'hFF0F, 5'b01011);
    check("ack_edge_if", {8'h0, dout}, 16'h00EA);

    // Edge beats same-cycle IF write and same-cycle ack.
    wr(16'hFF0F, 8'h00, 5'b11011);
    rd(16'hFF0F, 5'b11011);
    check("edge_vs_wr", {8'h0, dout}, 16'h00F0);
    idle(5'b01011);
    cyc(0, 16'h0000, 8'h00, 0, 0, 5'b11011, 8'h10);
    check("edge_vs_ack", {8'h0, irq}, 16'h0010);

    // Full register writes.
    wr(16'hFF0F, 8'hFF, 5'b11011);
    rd(16'hFF0F, 5'b11011);
    check("if_ff_read", {8'h0, dout}, 16'h00FF);
    check("if_ff_irq", {8'h0, irq}, 16'h001F);
    wr(16'hFFFF, 8'hE0, 5'b11011);
    rd(16'hFFFF, 5'b11011);
    check("ie_e0_read", {8'h0, dout}, 16'h00E0);
    check("ie_e0_irq", {8'h0, irq}, 16'h0);

    // Decode miss and read-during-write.
    rd(16'hFF10, 5'b11011);
    check("miss_valid", {15'h0, dout_valid}, 16'h0);
    check("miss_dout", {8'h0, dout}, 16'h00E0);
    wr(16'hFFFF, 8'h05, 5'b11011);
    cyc(0, 16'hFFFF, 8'h12, 1, 1, 5'b11011, 8'h00);
    check("rdwr_old", {8'h0, dout}, 16'h0005);
    rd(16'hFFFF, 5'b11011);
    check("rdwr_new", {8'h0, dout}, 16'h0012);

    // Randomized traffic, with occasional mid-operation resets.
    for (int k = 0; k < 600; k++) begin
      logic [15:0] a;
      logic [7:0]  ak;
      case ($urandom_range(0, 3))
        0: a = 16'hFF0F;
        1: a = 16'hFFFF;
        2: a = 16'hFF10;
        default: a = 16'($urandom);
      endcase
      ak = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc($urandom_range(0, 60) == 0, a, 8'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, 5'($urandom), ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
